uart_rx: RTL

Receives asynchronous 8-bit UART frames (8N1 by default) on a single serial input and presents each byte on a one-entry valid/ready output port. It is the receive counterpart to the board's `uart_tx` path: it takes the `uart_rx` pin and feeds bytes to the MCU core or the LCD/LED control logic. It synchronises the pin, oversamples 16x, majority-votes each bit and reports framing and overrun errors.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and the
// 2-of-3 majority helper. Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;
  localparam int unsigned DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output port of the UART receiver: one-entry valid/ready handshake.
// master = receiver side, slave = consumer side.
interface uart_rx_if
  import uart_pkg::*;
();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider: one-cycle tick every DIV clocks.
// Shared between uart_rx and uart_tx. DIV below 1 is treated as 1.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DivC = (DIV < 1) ? 1 : DIV;
  localparam int unsigned CntW = (DivC > 1) ? $clog2(DivC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DivC - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  // Count 0..DIV-1 and restart on every tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, 16x oversampling, 2-of-3 majority vote per
// bit, framing/overrun error pulses and a one-entry valid/ready output.
// Optional even parity (8E1) is enabled by defining UART_RX_PARITY_EN;
// the default build is 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 144_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  rx_out,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DivC = (DIV < 1) ? 1 : DIV;

  logic tick;

  uart_baud_tick #(
    .DIV(DivC)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Synchroniser, edge history and start arming.
  logic       sync1_q;
  logic       rx_sync_q;
  logic       rx_prev_q;
  logic [1:0] fill_q;
  logic       armed_q;

  // The sync stages reset high, so the line is only trusted once the chain has
  // been refilled from the pin; a line stuck low out of reset never arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= rx;
      rx_sync_q <= sync1_q;
      rx_prev_q <= rx_sync_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
      if (fill_q == 2'd2 && rx_sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  logic start_edge;
  assign start_edge = armed_q & rx_prev_q & ~rx_sync_q;

  // Receive state.
  uart_state_e          state_q;
  logic [3:0]           os_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 s_lo_q;
  logic                 s_mid_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 busy_q;
  logic                 byte_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign byte_bad = parity_err_q;
`else
  assign byte_bad = 1'b0;
`endif

  logic in_frame;
  logic vote_now;
  logic wrap_now;
  logic vote;

  assign in_frame = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);
  assign vote_now = in_frame && tick && (os_cnt_q == 4'(SAMPLE_HI));
  assign wrap_now = in_frame && tick && (os_cnt_q == 4'(OVERSAMPLE - 1));
  // Third sample is the live synchronised line at count 9.
  assign vote     = maj3(s_lo_q, s_mid_q, rx_sync_q);

  // Frame FSM with registered outputs and the holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      os_cnt_q    <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      s_lo_q      <= 1'b1;
      s_mid_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (rx_valid_q && rx_out.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (in_frame && tick) begin
        os_cnt_q <= os_cnt_q + 4'd1;
        if (os_cnt_q == 4'(SAMPLE_LO)) begin
          s_lo_q <= rx_sync_q;
        end
        if (os_cnt_q == 4'(SAMPLE_MID)) begin
          s_mid_q <= rx_sync_q;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q  <= StStart;
            os_cnt_q <= 4'd0;
            busy_q   <= 1'b1;
          end
        end

        StStart: begin
          if (vote_now && vote) begin
            // Start bit did not survive the vote: treat as a glitch.
            state_q  <= StIdle;
            os_cnt_q <= 4'd0;
            busy_q   <= 1'b0;
          end else if (wrap_now) begin
            state_q   <= StData;
            bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
          end
        end

        StData: begin
          if (vote_now) begin
            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          end
          if (wrap_now) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          // Even parity: data bits XOR parity bit must be zero.
          if (vote_now) begin
            parity_err_q <= (^shift_q) ^ vote;
          end
          if (wrap_now) begin
            state_q <= StStop;
          end
        end
`endif

        StStop: begin
          // Leave at count 9 so the next start edge is not missed.
          if (vote_now) begin
            os_cnt_q <= 4'd0;
            if (!vote) begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              if (byte_bad) begin
                frame_err_q <= 1'b1;
              end else if (!rx_valid_q || rx_out.rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
        end

        StBreak: begin
          if (rx_sync_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q  <= StIdle;
          os_cnt_q <= 4'd0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rx_out.rx_data  = rx_data_q;
  assign rx_out.rx_valid = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign busy            = busy_q;

endmodule
